// File: rtl/kmkz_mem_arbiter_if.sv
// Bus bundle for kmkz_mem_arbiter: fetch port, load/store port and the
// shared memory port. The master modport is the arbiter's view; the slave
// modport is the view of the surrounding requesters and memory.
interface kmkz_mem_arbiter_if;
  // fetch requester
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  // load/store requester
  logic        ls_req_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_rdata_o;
  logic        ls_ready_o;
  // shared memory port
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  modport master (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_rdata_o, if_ready_o,
    input  ls_req_i, ls_addr_i, ls_wdata_i, ls_we_i, ls_be_i,
    output ls_rdata_o, ls_ready_o,
    output mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_rdata_o, if_ready_o,
    output ls_req_i, ls_addr_i, ls_wdata_i, ls_we_i, ls_be_i,
    input  ls_rdata_o, ls_ready_o,
    input  mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/kmkz_mem_arbiter.sv
// kmkz_mem_arbiter: two-requester arbiter (instruction fetch and load/store)
// in front of a single-outstanding memory port. Load/store wins by default.
// Fetch responses can be discarded by a branch flush.
// Optional feature macro: KMKZ_ARB_FAIR_EN -- when defined, a starvation
// counter forces a fetch grant after STARVE_MAX consecutive load/store grants
// that passed over a waiting fetch. Default build: strict load/store priority.
module kmkz_mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  kmkz_mem_arbiter_if.master         bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    LS_WAIT = 2'd2
  } state_t;

  state_t state;
  logic   discard;
  logic   grant_if;
  logic   grant_ls;
  logic   fair_force;

  // The starvation counter is 3 bits wide, so the limit must fit in 1..7.
  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve_max
    $error("kmkz_mem_arbiter: STARVE_MAX must be in 1..7");
  end

`ifdef KMKZ_ARB_FAIR_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  logic [2:0] starve_cnt;

  // Count load/store grants that overtake a waiting fetch; a fetch grant clears it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt <= 3'd0;
    end else if (state == IDLE && grant_if) begin
      starve_cnt <= 3'd0;
    end else if (state == IDLE && grant_ls && bus.if_req_i && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 3'd1;
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  assign fair_force = bus.if_req_i && (starve_cnt == STARVE_LIM);
`else
  assign fair_force = 1'b0;
`endif

  // Pick the winner for an IDLE-state grant: load/store first unless a starved fetch is forced.
  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (bus.ls_req_i && !fair_force) begin
      grant_ls = 1'b1;
    end else if (bus.if_req_i) begin
      grant_if = 1'b1;
    end else begin
      grant_ls = 1'b0;
      grant_if = 1'b0;
    end
  end

  // Arbiter FSM: latch the winner onto the memory port, wait for ack, return data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      discard         <= 1'b0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_addr_o  <= 32'h0000_0000;
      bus.mem_wdata_o <= 32'h0000_0000;
      bus.mem_we_o    <= 1'b0;
      bus.mem_be_o    <= 4'h0;
      bus.if_rdata_o  <= 32'h0000_0000;
      bus.if_ready_o  <= 1'b0;
      bus.ls_rdata_o  <= 32'h0000_0000;
      bus.ls_ready_o  <= 1'b0;
    end else begin
      // ready outputs are single-cycle pulses
      bus.if_ready_o <= 1'b0;
      bus.ls_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ls) begin
            state           <= LS_WAIT;
            bus.mem_req_o   <= 1'b1;
            bus.mem_addr_o  <= bus.ls_addr_i;
            bus.mem_wdata_o <= bus.ls_wdata_i;
            bus.mem_we_o    <= bus.ls_we_i;
            bus.mem_be_o    <= bus.ls_be_i;
          end else if (grant_if) begin
            state           <= IF_WAIT;
            bus.mem_req_o   <= 1'b1;
            bus.mem_addr_o  <= bus.if_addr_i;
            bus.mem_wdata_o <= 32'h0000_0000;
            bus.mem_we_o    <= 1'b0;
            bus.mem_be_o    <= 4'hF;
            // a flush arriving with the grant already dooms this fetch
            discard         <= bus.if_flush_i;
          end
        end
        IF_WAIT: begin
          if (bus.mem_ack_i) begin
            state          <= IDLE;
            bus.mem_req_o  <= 1'b0;
            bus.if_rdata_o <= bus.mem_rdata_i;
            bus.if_ready_o <= !(discard || bus.if_flush_i);
            discard        <= 1'b0;
          end else if (bus.if_flush_i) begin
            discard <= 1'b1;
          end
        end
        LS_WAIT: begin
          if (bus.mem_ack_i) begin
            state          <= IDLE;
            bus.mem_req_o  <= 1'b0;
            bus.ls_rdata_o <= bus.mem_rdata_i;
            bus.ls_ready_o <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.mem_req_o <= 1'b0;
          discard       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmkz_mem_arbiter.sv
// Self-checking bench for kmkz_mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
// Honours KMKZ_ARB_FAIR_EN the same way the design does.
module tb_kmkz_mem_arbiter;
  localparam int STARVE = 4;
`ifdef KMKZ_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  kmkz_mem_arbiter_if bus();

  kmkz_mem_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int          starve;
  logic [31:0] m_if_rdata;
  logic [31:0] m_ls_rdata;
  bit          m_if_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Load/store has priority; in fair builds a fetch that has watched STARVE
  // load/store grants go by is served first.
  function automatic bit model_pick_if(bit ifr, bit lsr, int cnt);
    if (!lsr) return ifr;
    if (FAIR && ifr && cnt >= STARVE) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    starve     = 0;
    m_if_rdata = 32'h0;
    m_ls_rdata = 32'h0;
    m_if_known = 1'b1;
  endtask

  // One complete transaction. flush_at: -1 none, 0 with the grant,
  // 1..delay in that wait cycle, delay+1 together with the ack.
  task automatic run_txn(input string tag, input bit ifr, input logic [31:0] ifa,
                         input bit lsr, input logic [31:0] lsa, input logic [31:0] lsd,
                         input bit lswe, input logic [3:0] lsbe, input int delay,
                         input logic [31:0] rdata, input int flush_at,
                         output bit took_if, output logic [31:0] granted_addr);
    bit pick_if;
    bit disc;
    pick_if = model_pick_if(ifr, lsr, starve);
    disc    = pick_if && (flush_at >= 0);
    bus.if_req_i   = ifr;  bus.if_addr_i  = ifa;
    bus.ls_req_i   = lsr;  bus.ls_addr_i  = lsa;
    bus.ls_wdata_i = lsd;  bus.ls_we_i    = lswe;  bus.ls_be_i = lsbe;
    bus.if_flush_i = (flush_at == 0);
    tick();
    bus.if_flush_i = 1'b0;
    if (pick_if) starve = 0;
    else if (ifr) starve = (starve < STARVE) ? starve + 1 : STARVE;
    granted_addr = bus.mem_addr_o;
    chk({tag, ".mem_req"}, bus.mem_req_o, 32'd1);
    chk({tag, ".mem_addr"}, bus.mem_addr_o, pick_if ? ifa : lsa);
    chk({tag, ".mem_we"}, bus.mem_we_o, pick_if ? 32'd0 : 32'(lswe));
    chk({tag, ".mem_be"}, bus.mem_be_o, pick_if ? 32'hF : 32'(lsbe));
    if (!pick_if) chk({tag, ".mem_wdata"}, bus.mem_wdata_o, lsd);
    for (int c = 1; c <= delay; c++) begin
      bus.if_flush_i  = (flush_at == c);
      bus.mem_rdata_i = $urandom;
      tick();
      bus.if_flush_i = 1'b0;
      chk({tag, ".wait_req"}, bus.mem_req_o, 32'd1);
      chk({tag, ".wait_addr"}, bus.mem_addr_o, pick_if ? ifa : lsa);
      chk({tag, ".wait_rdy"}, {bus.if_ready_o, bus.ls_ready_o}, 32'd0);
      chk({tag, ".ls_hold"}, bus.ls_rdata_o, m_ls_rdata);
      if (m_if_known) chk({tag, ".if_hold"}, bus.if_rdata_o, m_if_rdata);
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = rdata;
    bus.if_flush_i  = (flush_at == delay + 1);
    tick();
    bus.mem_ack_i   = 1'b0;
    bus.if_flush_i  = 1'b0;
    bus.mem_rdata_i = $urandom;
    chk({tag, ".done_req"}, bus.mem_req_o, 32'd0);
    if (pick_if) begin
      chk({tag, ".if_ready"}, bus.if_ready_o, disc ? 32'd0 : 32'd1);
      chk({tag, ".ls_ready"}, bus.ls_ready_o, 32'd0);
      if (!disc) begin
        chk({tag, ".if_rdata"}, bus.if_rdata_o, rdata);
        m_if_rdata = rdata;
        m_if_known = 1'b1;
      end else begin
        m_if_known = 1'b0;
      end
      chk({tag, ".ls_hold2"}, bus.ls_rdata_o, m_ls_rdata);
      bus.if_req_i = 1'b0;
    end else begin
      chk({tag, ".ls_ready"}, bus.ls_ready_o, 32'd1);
      chk({tag, ".if_ready"}, bus.if_ready_o, 32'd0);
      chk({tag, ".ls_rdata"}, bus.ls_rdata_o, rdata);
      m_ls_rdata = rdata;
      if (m_if_known) chk({tag, ".if_hold2"}, bus.if_rdata_o, m_if_rdata);
      bus.ls_req_i = 1'b0;
    end
    took_if = pick_if;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_req"}, bus.mem_req_o, 32'd0);
    chk({tag, ".mem_addr"}, bus.mem_addr_o, 32'd0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata_o, 32'd0);
    chk({tag, ".mem_we_be"}, {bus.mem_we_o, bus.mem_be_o}, 32'd0);
    chk({tag, ".rdata"}, {bus.if_rdata_o | bus.ls_rdata_o}, 32'd0);
    chk({tag, ".ready"}, {bus.if_ready_o, bus.ls_ready_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          took;
    logic [31:0] ga;
    bit          ifp, lsp, we;
    logic [31:0] ifa, lsa, lsd;
    logic [3:0]  be;
    int          d, fa;

    rst_i = 1'b0;
    bus.if_req_i = 1'b0;  bus.if_addr_i = 32'h0;  bus.if_flush_i = 1'b0;
    bus.ls_req_i = 1'b0;  bus.ls_addr_i = 32'h0;  bus.ls_wdata_i = 32'h0;
    bus.ls_we_i  = 1'b0;  bus.ls_be_i   = 4'h0;
    bus.mem_rdata_i = 32'h0;  bus.mem_ack_i = 1'b0;
    model_reset();
    tick();
    tick();
    chk_all_zero("reset");
    rst_i = 1'b1;
    tick();

    // plain fetch
    run_txn("if_only", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 0, 32'hDEAD_BEEF, -1, took, ga);

    // simultaneous fetch and store: store first, then the held fetch
    run_txn("sim_ls", 1'b1, 32'h104, 1'b1, 32'h2000, 32'h1234_5678, 1'b1, 4'b0011, 0, 32'h0BAD_F00D, -1, took, ga);
    run_txn("sim_if", 1'b1, 32'h104, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1, 32'hCAFE_0104, -1, took, ga);

    // ack while idle is ignored
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    chk("idle_ack.ready", {bus.if_ready_o, bus.ls_ready_o}, 32'd0);
    chk("idle_ack.req", bus.mem_req_o, 32'd0);

    // flush in IDLE has no effect on a later fetch
    bus.if_flush_i = 1'b1;
    tick();
    bus.if_flush_i = 1'b0;
    run_txn("flush_idle", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 0, 32'h0000_0200, -1, took, ga);

    // flush during IF_WAIT, ack three cycles later: discarded, next fetch normal
    run_txn("flush_wait", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 3, 32'h3333_3333, 1, took, ga);
    run_txn("after_flush", 1'b1, 32'h400, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 0, 32'h4444_4444, -1, took, ga);
    // flush together with the grant and together with the ack
    run_txn("flush_grant", 1'b1, 32'h500, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1, 32'h5555_5555, 0, took, ga);
    run_txn("flush_ack", 1'b1, 32'h600, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 2, 32'h6666_6666, 3, took, ga);
    // flush during a load is ignored and leaves the next fetch alone
    run_txn("flush_ls", 1'b0, 32'h0, 1'b1, 32'h700, 32'h0, 1'b0, 4'hF, 2, 32'h7777_7777, 1, took, ga);
    run_txn("if_after_ls", 1'b1, 32'h800, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 0, 32'h8888_8888, -1, took, ga);

    // randomized traffic; requesters hold until served
    ifp = 1'b0;  lsp = 1'b0;
    ifa = 32'h0; lsa = 32'h0; lsd = 32'h0; we = 1'b0; be = 4'h0;
    for (int t = 0; t < 40; t++) begin
      if (!ifp && $urandom_range(0, 1) == 1) begin
        ifp = 1'b1;
        ifa = $urandom & 32'hFFFF_FFFC;
      end
      if (!lsp && $urandom_range(0, 1) == 1) begin
        lsp = 1'b1;
        lsa = $urandom & 32'hFFFF_FFFC;
        lsd = $urandom;
        we  = 1'($urandom_range(0, 1));
        be  = 4'($urandom_range(0, 15));
      end
      if (!ifp && !lsp) begin
        lsp = 1'b1;
        lsa = $urandom & 32'hFFFF_FFFC;
        lsd = $urandom;
        we  = 1'b1;
        be  = 4'hF;
      end
      d  = $urandom_range(0, 3);
      fa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, d + 1) : -1;
      run_txn("rand", ifp, ifa, lsp, lsa, lsd, we, be, d, $urandom, fa, took, ga);
      if (took) ifp = 1'b0;
      else lsp = 1'b0;
    end
    bus.if_req_i = 1'b0;
    bus.ls_req_i = 1'b0;
    tick();

    // reset in the middle of a load
    bus.ls_req_i = 1'b1;  bus.ls_addr_i = 32'h9000;  bus.ls_wdata_i = 32'h0;
    bus.ls_we_i  = 1'b0;  bus.ls_be_i   = 4'hF;
    tick();
    chk("rst_mid.granted", bus.mem_req_o, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    bus.ls_req_i = 1'b0;
    model_reset();
    tick();
    rst_i = 1'b1;
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i = 1'b0;
    chk("rst_stray.ready", {bus.if_ready_o, bus.ls_ready_o}, 32'd0);
    chk("rst_stray.req", bus.mem_req_o, 32'd0);

    // both requesters held high: grant order with and without fairness
    for (int k = 0; k < 10; k++) begin
      run_txn("fair", 1'b1, 32'h100, 1'b1, 32'h2000, 32'hA5A5_0000 + 32'(k), 1'b1, 4'hF, 0, $urandom, -1, took, ga);
      chk("fair.grant_order", ga, (FAIR && (k % 5 == 4)) ? 32'h100 : 32'h2000);
    end
    bus.if_req_i = 1'b0;
    bus.ls_req_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
